// File: rtl/timer_pkg.sv
// Shared definitions for the loadable down timer.
// State encoding and default counter width.
package timer_pkg;

  localparam int TIMER_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle of the down timer.
// The master drives commands, the slave reports status.
interface down_timer_if #(
  parameter int N = 4
);

  logic         start;
  logic         stop;
  logic         periodic;
  logic [N-1:0] load_val;
  logic         busy;
  logic [N-1:0] count;
  logic [N-1:0] elapsed;
  logic         done;
  logic         expired;

  modport master (
    output start, stop, periodic, load_val,
    input  busy, count, elapsed, done, expired
  );

  modport slave (
    input  start, stop, periodic, load_val,
    output busy, count, elapsed, done, expired
  );

endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer, one-shot or periodic.
// FSM and datapath share one module.
module down_timer
  import timer_pkg::*;
#(
  parameter int N = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  tif
);

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] elapsed_q, elapsed_d;
  logic [N-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic         expired_q, expired_d;

  // Next state: stop beats start, start beats expiry/decrement.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    elapsed_d = elapsed_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    expired_d = expired_q;
    if (tif.stop) begin
      state_d   = ST_IDLE;
      expired_d = 1'b0;
    end else if (tif.start) begin
      state_d   = ST_RUN;
      reload_d  = tif.load_val;
      mode_d    = tif.periodic;
      count_d   = tif.load_val;
      elapsed_d = '0;
      expired_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (count_q == '0) begin
            done_d = 1'b1;
            if (mode_q) begin
              count_d   = reload_q;
              elapsed_d = '0;
            end else begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end
          end else begin
            count_d   = count_q - ONE;
            elapsed_d = elapsed_q + ONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      elapsed_q <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign tif.busy    = (state_q == ST_RUN);
  assign tif.count   = count_q;
  assign tif.elapsed = elapsed_q;
  assign tif.done    = done_q;
  assign tif.expired = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer.
// Expected outputs come from a time-since-start model.
module tb_down_timer;

  localparam int N = 4;

  typedef struct packed {
    logic         busy;
    logic [N-1:0] count;
    logic [N-1:0] elapsed;
    logic         done;
    logic         expired;
  } exp_t;

  logic clk;
  logic rst;

  down_timer_if #(.N(N)) tif ();

  down_timer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif.slave)
  );

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;

  // reference model state
  bit   m_run;
  int   m_k;
  int   m_l;
  bit   m_per;
  exp_t cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Apply one edge worth of inputs and predict the outputs after it.
  task automatic step(input bit r, input bit st, input bit sp,
                      input bit per, input int lv);
    int ph;
    @(negedge clk);
    rst          = r;
    tif.start    = st;
    tif.stop     = sp;
    tif.periodic = per;
    tif.load_val = N'(lv);
    if (!r) begin
      m_run = 0;
      cur   = '0;
    end else if (sp) begin
      m_run       = 0;
      cur.busy    = 0;
      cur.done    = 0;
      cur.expired = 0;
    end else if (st) begin
      m_run = 1;
      m_k   = 0;
      m_l   = lv;
      m_per = per;
      cur   = '{busy: 1, count: N'(lv), elapsed: '0,
                done: 0, expired: 0};
    end else if (m_run) begin
      m_k++;
      if (m_per) begin
        ph          = m_k % (m_l + 1);
        cur.busy    = 1;
        cur.count   = N'(m_l - ph);
        cur.elapsed = N'(ph);
        cur.done    = (ph == 0);
        cur.expired = 0;
      end else if (m_k <= m_l) begin
        cur.count   = N'(m_l - m_k);
        cur.elapsed = N'(m_k);
        cur.done    = 0;
      end else begin
        m_run       = 0;
        cur.busy    = 0;
        cur.count   = '0;
        cur.elapsed = N'(m_l);
        cur.done    = 1;
        cur.expired = 1;
      end
    end else begin
      cur.done = 0;
    end
    q.push_back(cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle's outputs with the oldest prediction.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{busy: tif.busy, count: tif.count,
              elapsed: tif.elapsed, done: tif.done,
              expired: tif.expired};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got b=%b c=%0d e=%0d d=%b x=%b exp b=%b c=%0d e=%0d d=%b x=%b",
                   cyc, a.busy, a.count, a.elapsed, a.done, a.expired,
                   e.busy, e.count, e.elapsed, e.done, e.expired);
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    m_run        = 0;
    cur          = '0;
    rst          = 1'b0;
    tif.start    = 1'b0;
    tif.stop     = 1'b0;
    tif.periodic = 1'b0;
    tif.load_val = '0;

    step(0, 1, 0, 1, 9);
    step(0, 1, 0, 0, 9);
    idle(2);
    // one-shot 5
    step(1, 1, 0, 0, 5);
    idle(9);
    // periodic 2
    step(1, 1, 0, 1, 2);
    idle(12);
    step(1, 0, 1, 0, 0);
    idle(2);
    // stop at count 3
    step(1, 1, 0, 0, 7);
    idle(4);
    step(1, 0, 1, 0, 0);
    idle(5);
    // stop on terminal edge
    step(1, 1, 0, 0, 2);
    idle(2);
    step(1, 0, 1, 0, 0);
    idle(3);
    // restart mid-run, then start+stop together
    step(1, 1, 0, 0, 5);
    idle(3);
    step(1, 1, 0, 0, 9);
    idle(3);
    step(1, 1, 1, 1, 4);
    idle(3);
    // zero interval, one-shot and periodic
    step(1, 1, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 1, 0);
    idle(3);
    step(1, 0, 1, 0, 0);
    // full interval
    step(1, 1, 0, 0, 15);
    idle(18);
    // reset mid-run
    step(1, 1, 0, 1, 6);
    idle(2);
    step(0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0,
           $urandom_range(15) == 0,
           $urandom_range(29) == 0,
           $urandom_range(1) == 1,
           $urandom_range(15));
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions unchecked, required 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
